// File: rtl/spi_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_fsm
// Description : Transaction controller for the SPI slave path. Counts
//               conditioned SCLK edge strobes, decodes the read/write bit of
//               the address byte and sequences the address latch, the shift
//               register parallel load, the data memory write and the MISO
//               output enable.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BITS        bits per SPI byte (1..15, the bit counter is 4 bits wide)
// Ports
//   clk         in   system clock, all state updates on posedge
//   resetN      in   asynchronous active-low reset
//   sclkPosedge in   one-clk strobe per conditioned SCLK rising edge
//   sclkNegedge in   one-clk strobe per conditioned SCLK falling edge
//   chipSel     in   conditioned chip select, active low
//   rwBit       in   shift register LSB after the address byte, 1 = read
//   addrWe      out  one-cycle pulse, latch the address byte
//   srWe        out  one-cycle pulse, parallel-load the shift register
//   dmWe        out  one-cycle pulse, write shift register to data memory
//   misoBufe    out  MISO driver enable, high for the whole read data phase
//   abortFlag   out  sticky abort indication (only with SPI_FSM_ABORT_EN)
// Build option
//   SPI_FSM_ABORT_EN  adds the abortFlag output
// ============================================================================
module spi_slave_fsm #(
  parameter int BITS = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic sclkPosedge,
  input  logic sclkNegedge,
  input  logic chipSel,
  input  logic rwBit,
  output logic addrWe,
  output logic srWe,
  output logic dmWe,
  output logic misoBufe
`ifdef SPI_FSM_ABORT_EN
  ,
  output logic abortFlag
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET       = 3'd1,
    ST_GOT       = 3'd2,
    ST_READ_LOAD = 3'd3,
    ST_READ      = 3'd4,
    ST_WRITE     = 3'd5,
    ST_WRITE_DM  = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  // Terminal count of the 4-bit bit counter.
  localparam logic [3:0] CNT_LAST = 4'(BITS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt + 4'd1;

  // --------------------------------------------------------------------------
  // Next-state and counter logic. The counting states leave on the very
  // strobe that brings the counter to CNT_LAST, so the counter never wraps.
  // Chip select deasserted overrides every transition and every strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (chipSel) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_GET;
          cnt_nxt   = 4'd0;
        end
        ST_GET: begin
          // Address byte is shifted on SCLK rising edges only.
          if (sclkPosedge) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_nxt = ST_GOT;
            end
          end
        end
        ST_GOT: begin
          if (rwBit) begin
            state_nxt = ST_READ_LOAD;
          end else begin
            state_nxt = ST_WRITE;
            cnt_nxt   = 4'd0;
          end
        end
        ST_READ_LOAD: begin
          state_nxt = ST_READ;
          cnt_nxt   = 4'd0;
        end
        ST_READ: begin
          // Read data is driven out on SCLK falling edges.
          if (sclkNegedge) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (sclkPosedge) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_nxt = ST_WRITE_DM;
            end
          end
        end
        ST_WRITE_DM: begin
          state_nxt = ST_DONE;
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register. Outputs are registered decodes of the state being
  // entered, so each output is a pure function of the current state while
  // still changing on the same edge as the state itself.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      addrWe   <= 1'b0;
      srWe     <= 1'b0;
      dmWe     <= 1'b0;
      misoBufe <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addrWe   <= (state_nxt == ST_GOT);
      srWe     <= (state_nxt == ST_READ_LOAD);
      dmWe     <= (state_nxt == ST_WRITE_DM);
      misoBufe <= (state_nxt == ST_READ);
    end
  end

`ifdef SPI_FSM_ABORT_EN
  // Sticky abort flag: a chip-select release in any active state before the
  // transaction reached DONE marks the transaction as aborted. Releasing
  // chip select in DONE or IDLE is a normal end and leaves the flag alone.
  logic abort_seen;

  assign abort_seen = chipSel &&
                      (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      abortFlag <= 1'b0;
    end else if (abort_seen) begin
      abortFlag <= 1'b1;
    end else if ((state == ST_IDLE) && !chipSel) begin
      abortFlag <= 1'b0;
    end
  end
`else
  // Without the abort option an early chip-select release simply returns
  // the controller to IDLE and no status is retained.
`endif

endmodule

`default_nettype wire
